mux_rr_arbiter: RTL and testbench
=================================

MUX_RR_ARBITER -- requirements
Module: mux_rr_arbiter

Interface
REQ-001 Parameter: MAX_TENURE, default 8, maximum consecutive GRANT cycles per owner while another requester waits; legal range 1..255.
REQ-002 Port: clock  input  1  single system clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: req  input  4  request from requesters 0..3; level-sensitive, held high while access is wanted.
REQ-005 Port: data  input  4  data bit of requesters 0..3; mux input i = data[i].
REQ-006 Port: grant  output  4  one-hot grant; all-zero when idle.
REQ-007 Port: sel  output  2  encoded index of current owner; drives the 4:1 mux select.
REQ-008 Port: valid  output  1  high when grant is non-zero.
REQ-009 Port: y  output  1  shared mux output: data[sel] when valid, else 0.
REQ-010 Port: handoffs  output  8  count of grant changes between requesters.

Function
REQ-011 grant, sel, valid, handoffs, the priority pointer and the tenure counter SHALL be registers; y SHALL be combinational from registered sel/valid and live data.
REQ-012 FSM states SHALL be IDLE (no owner) and OWNED (one owner).
REQ-013 Round-robin order SHALL search from last_owner+1 upward, modulo 4; the pointer updates to the index of every new grant.
REQ-014 IDLE, any req high: next edge -> OWNED, grant the first requester in RR order, tenure = 0; latency req-to-grant is exactly 1 cycle.
REQ-015 IDLE, no req: stay IDLE, outputs held at idle values.
REQ-016 OWNED, owner req high, tenure < MAX_TENURE-1: keep owner, tenure += 1.
REQ-017 OWNED, owner req high, tenure = MAX_TENURE-1, another req high: next edge grant next requester in RR order after owner, tenure = 0, no idle bubble.
REQ-018 OWNED, owner req high, tenure = MAX_TENURE-1, no other req: keep owner, tenure = 0.
REQ-019 OWNED, owner req low, another req high: next edge grant next requester in RR order after owner, tenure = 0.
REQ-020 OWNED, owner req low, no other req: next edge -> IDLE; grant = 0, valid = 0, sel holds last value.
REQ-021 Owner releasing and re-requesting in the same cycle as others request SHALL be treated as a release (REQ-019 order; owner is last in search).
REQ-022 grant SHALL never have more than one bit set; sel SHALL equal the index of the set grant bit whenever valid = 1.
REQ-023 handoffs SHALL increment by 1 on each edge where a grant passes from one owner to a different owner (REQ-017, REQ-019); IDLE->OWNED and re-grant to the same index after IDLE do not count; wraps 255 -> 0.
REQ-024 MAX_TENURE = 1 SHALL rotate every cycle while two or more requesters are active.

Reset
REQ-025 reset high at an edge SHALL force IDLE, grant = 0, sel = 0, valid = 0, handoffs = 0, tenure = 0, last_owner = 3 (requester 0 wins first); y = 0 follows.
REQ-026 Reset SHALL override all other inputs, including mid-tenure; first grant after reset release follows REQ-014 with last_owner = 3.

Verification
REQ-027 Reset, then req = 4'b0110 held -> 1 cycle later grant = 4'b0010, sel = 1, valid = 1; after 8 cycles of ownership (MAX_TENURE = 8) grant = 4'b0100, handoffs = 1.
REQ-028 req = 4'b1111 held, MAX_TENURE = 1 -> grant sequence 0001, 0010, 0100, 1000, 0001 on consecutive cycles; handoffs increments each cycle after the first grant.
REQ-029 Single owner req = 4'b0001 held 20 cycles -> grant stays 4'b0001 throughout, handoffs stays 0; data[0] toggled -> y follows same cycle.
REQ-030 Owner 2 drops req while req[0] high -> next edge grant = 4'b0001; all req drop -> next edge grant = 0, valid = 0, y = 0 regardless of data.
REQ-031 Assert reset during OWNED at tenure 5 with handoffs = 3 -> next edge all outputs at REQ-025 values; release with req = 4'b1000 -> grant = 4'b1000 one cycle later.
REQ-032 Drive handoffs past 255 with continuous rotation -> value wraps to 0; at every cycle grant is one-hot or zero and sel matches it.

Source files
------------

// File: rtl/mux_rr_arbiter.sv
// Four-requester round-robin arbiter driving a shared 4:1 mux, with a
// tenure limit per owner and a wrapping count of owner-to-owner handoffs.
module mux_rr_arbiter #(
    parameter int MAX_TENURE = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] req,
    input  logic [3:0] data,
    output logic [3:0] grant,
    output logic [1:0] sel,
    output logic       valid,
    output logic       y,
    output logic [7:0] handoffs
);

    typedef enum logic {
        IDLE,
        OWNED
    } state_t;

    localparam logic [7:0] TEN_LAST = 8'(MAX_TENURE - 1);

    state_t     state_q;
    logic [3:0] grant_q;
    logic [1:0] sel_q;
    logic       valid_q;
    logic [7:0] handoffs_q;
    logic [7:0] tenure_q;
    logic [1:0] ptr_q;

    logic [3:0] search_mask;
    logic [1:0] cand;
    logic [1:0] pick_d;
    logic       pick_hit;
    logic       owner_req;

    // The owner is masked out of the search, so it is never its own successor;
    // in IDLE grant_q is zero and the mask is simply req, owner-last order holds.
    always_comb begin
        search_mask = req & ~grant_q;
        owner_req   = |(req & grant_q);
        cand        = '0;
        pick_d      = ptr_q;
        pick_hit    = 1'b0;
        for (int unsigned k = 1; k <= 4; k++) begin
            cand = 2'(ptr_q + 2'(k));
            if (!pick_hit && search_mask[cand]) begin
                pick_d   = cand;
                pick_hit = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            sel_q      <= '0;
            valid_q    <= 1'b0;
            handoffs_q <= '0;
            tenure_q   <= '0;
            ptr_q      <= 2'd3;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_hit) begin
                        state_q  <= OWNED;
                        grant_q  <= 4'b0001 << pick_d;
                        sel_q    <= pick_d;
                        valid_q  <= 1'b1;
                        ptr_q    <= pick_d;
                        tenure_q <= '0;
                    end
                end
                OWNED: begin
                    if (owner_req && tenure_q != TEN_LAST) begin
                        tenure_q <= tenure_q + 8'd1;
                    end else if (pick_hit) begin
                        grant_q    <= 4'b0001 << pick_d;
                        sel_q      <= pick_d;
                        ptr_q      <= pick_d;
                        tenure_q   <= '0;
                        handoffs_q <= handoffs_q + 8'd1;
                    end else if (owner_req) begin
                        tenure_q <= '0;
                    end else begin
                        state_q  <= IDLE;
                        grant_q  <= '0;
                        valid_q  <= 1'b0;
                        tenure_q <= '0;
                    end
                end
            endcase
        end
    end

    assign grant    = grant_q;
    assign sel      = sel_q;
    assign valid    = valid_q;
    assign handoffs = handoffs_q;
    assign y        = valid_q & data[sel_q];

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Bench for mux_rr_arbiter: two instances (tenure 8 and 1) share stimulus and
// are compared every cycle against a rule-level model, plus vectors and sequences.
module tb_mux_rr_arbiter;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] req;
    logic [3:0] data;

    logic [3:0] grant8, grant1;
    logic [1:0] sel8, sel1;
    logic       valid8, valid1, y8, y1;
    logic [7:0] ho8, ho1;

    always #5 clock = ~clock;

    mux_rr_arbiter #(.MAX_TENURE(8)) u8 (
        .clock(clock), .reset(reset), .req(req), .data(data),
        .grant(grant8), .sel(sel8), .valid(valid8), .y(y8), .handoffs(ho8)
    );

    mux_rr_arbiter #(.MAX_TENURE(1)) u1 (
        .clock(clock), .reset(reset), .req(req), .data(data),
        .grant(grant1), .sel(sel1), .valid(valid1), .y(y1), .handoffs(ho1)
    );

    int checks = 0;
    int errors = 0;

    // Model state per instance: owner index or -1 when nobody owns the mux.
    int m_owner[2];
    int m_last[2];
    int m_ten[2];
    int m_ho[2];
    int m_sel[2];
    int maxt[2] = '{8, 1};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int rr_pick(input int last, input logic [3:0] mask);
        for (int i = 1; i <= 4; i++)
            if (mask[(last + i) % 4]) return (last + i) % 4;
        return -1;
    endfunction

    task automatic model_step(input int k);
        int         nxt;
        logic       owns;
        logic [3:0] others;
        if (reset) begin
            m_owner[k] = -1; m_last[k] = 3; m_ten[k] = 0; m_ho[k] = 0; m_sel[k] = 0;
        end else if (m_owner[k] < 0) begin
            nxt = rr_pick(m_last[k], req);
            if (nxt >= 0) begin
                m_owner[k] = nxt; m_last[k] = nxt; m_sel[k] = nxt; m_ten[k] = 0;
            end
        end else begin
            owns   = req[m_owner[k]];
            others = req & ~(4'b0001 << m_owner[k]);
            if (owns && m_ten[k] < maxt[k] - 1) begin
                m_ten[k]++;
            end else if (others != 4'b0000) begin
                nxt = rr_pick(m_owner[k], others);
                m_ho[k] = (m_ho[k] + 1) % 256;
                m_owner[k] = nxt; m_last[k] = nxt; m_sel[k] = nxt; m_ten[k] = 0;
            end else if (owns) begin
                m_ten[k] = 0;
            end else begin
                m_owner[k] = -1; m_ten[k] = 0;
            end
        end
    endtask

    task automatic model_check(input int k);
        logic [3:0] g, eg;
        logic [1:0] s;
        logic       v, yy, ev, ey;
        logic [7:0] h;
        string      p;
        if (k == 0) begin
            g = grant8; s = sel8; v = valid8; yy = y8; h = ho8; p = "u8";
        end else begin
            g = grant1; s = sel1; v = valid1; yy = y1; h = ho1; p = "u1";
        end
        ev = (m_owner[k] >= 0);
        eg = ev ? (4'b0001 << m_owner[k]) : 4'b0000;
        ey = ev ? data[m_sel[k]] : 1'b0;
        chk({p, ".model.grant"}, 32'(g), 32'(eg));
        chk({p, ".model.valid"}, 32'(v), 32'(ev));
        chk({p, ".model.sel"}, 32'(s), 32'(m_sel[k]));
        chk({p, ".model.handoffs"}, 32'(h), 32'(m_ho[k]));
        chk({p, ".model.y"}, 32'(yy), 32'(ey));
        chk({p, ".onehot0"}, 32'($onehot0(g)), 32'd1);
        if (v) chk({p, ".sel_matches_grant"}, 32'(g == (4'b0001 << s)), 32'd1);
    endtask

    task automatic tick();
        @(posedge clock);
        model_step(0);
        model_step(1);
        @(negedge clock);
        model_check(0);
        model_check(1);
    endtask

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [3:0] data;
        logic [3:0] g;
        logic [1:0] s;
        logic       v;
        logic       y;
        logic [7:0] ho;
    } vec_t;

    vec_t tbl[11];

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] seq_g[5];
        // Expected outputs of the tenure-8 instance after each vector's edge.
        tbl[0]  = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 8'd0};
        tbl[1]  = '{1'b0, 4'b0110, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b1, 8'd0};
        tbl[2]  = '{1'b0, 4'b0100, 4'b0010, 4'b0100, 2'd2, 1'b1, 1'b0, 8'd1};
        tbl[3]  = '{1'b0, 4'b0101, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b1, 8'd1};
        tbl[4]  = '{1'b0, 4'b0001, 4'b0100, 4'b0001, 2'd0, 1'b1, 1'b0, 8'd2};
        tbl[5]  = '{1'b0, 4'b0000, 4'b1111, 4'b0000, 2'd0, 1'b0, 1'b0, 8'd2};
        tbl[6]  = '{1'b0, 4'b0001, 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b1, 8'd2};
        tbl[7]  = '{1'b0, 4'b1001, 4'b0000, 4'b0001, 2'd0, 1'b1, 1'b0, 8'd2};
        tbl[8]  = '{1'b0, 4'b1000, 4'b1000, 4'b1000, 2'd3, 1'b1, 1'b1, 8'd3};
        tbl[9]  = '{1'b1, 4'b1111, 4'b1111, 4'b0000, 2'd0, 1'b0, 1'b0, 8'd0};
        tbl[10] = '{1'b0, 4'b1010, 4'b0000, 4'b0010, 2'd1, 1'b1, 1'b0, 8'd0};

        reset = 1'b1; req = '0; data = '0;
        for (int k = 0; k < 2; k++) begin
            m_owner[k] = -1; m_last[k] = 3; m_ten[k] = 0; m_ho[k] = 0; m_sel[k] = 0;
        end

        for (int i = 0; i < 11; i++) begin
            reset = tbl[i].rst; req = tbl[i].req; data = tbl[i].data;
            tick();
            chk($sformatf("vec%0d.grant", i), 32'(grant8), 32'(tbl[i].g));
            chk($sformatf("vec%0d.sel", i), 32'(sel8), 32'(tbl[i].s));
            chk($sformatf("vec%0d.valid", i), 32'(valid8), 32'(tbl[i].v));
            chk($sformatf("vec%0d.y", i), 32'(y8), 32'(tbl[i].y));
            chk($sformatf("vec%0d.handoffs", i), 32'(ho8), 32'(tbl[i].ho));
        end

        // Tenure expiry with a waiting requester.
        reset = 1'b1; req = '0; tick();
        reset = 1'b0; req = 4'b0110; tick();
        chk("tenure.first_grant", 32'(grant8), 32'h2);
        chk("tenure.first_sel", 32'(sel8), 32'd1);
        chk("tenure.first_valid", 32'(valid8), 32'd1);
        repeat (7) tick();
        chk("tenure.last_owned", 32'(grant8), 32'h2);
        tick();
        chk("tenure.rotated", 32'(grant8), 32'h4);
        chk("tenure.handoffs", 32'(ho8), 32'd1);

        // Rotate every cycle with tenure 1.
        seq_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        reset = 1'b1; req = '0; tick();
        reset = 1'b0; req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("rot%0d.grant", i), 32'(grant1), 32'(seq_g[i]));
            chk($sformatf("rot%0d.handoffs", i), 32'(ho1), 32'(i));
        end

        // Lone owner keeps the mux indefinitely; y tracks live data.
        reset = 1'b1; req = '0; data = '0; tick();
        reset = 1'b0; req = 4'b0001;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk($sformatf("solo%0d.grant", i), 32'(grant8), 32'h1);
            chk($sformatf("solo%0d.handoffs", i), 32'(ho8), 32'd0);
        end
        data = 4'b0001; #1;
        chk("solo.y_rise", 32'(y8), 32'd1);
        data = 4'b1110; #1;
        chk("solo.y_fall", 32'(y8), 32'd0);

        // Reset in mid-tenure with non-zero handoffs.
        reset = 1'b1; req = '0; tick();
        reset = 1'b0;
        req = 4'b0001; tick();
        req = 4'b0010; tick();
        req = 4'b0100; tick();
        req = 4'b1000; tick();
        repeat (5) tick();
        chk("midrst.pre_handoffs", 32'(ho8), 32'd3);
        chk("midrst.pre_grant", 32'(grant8), 32'h8);
        reset = 1'b1; req = 4'b1111; data = 4'b1111; tick();
        chk("midrst.grant", 32'(grant8), 32'h0);
        chk("midrst.sel", 32'(sel8), 32'd0);
        chk("midrst.valid", 32'(valid8), 32'd0);
        chk("midrst.handoffs", 32'(ho8), 32'd0);
        chk("midrst.y", 32'(y8), 32'd0);
        reset = 1'b0; req = 4'b1000; tick();
        chk("midrst.regrant", 32'(grant8), 32'h8);
        chk("midrst.regrant_sel", 32'(sel8), 32'd3);

        // Handoff counter wraps under continuous rotation.
        reset = 1'b1; req = '0; tick();
        reset = 1'b0; req = 4'b1111;
        for (int n = 1; n <= 257; n++) begin
            tick();
            if (n == 256) chk("wrap.at255", 32'(ho1), 32'd255);
            if (n == 257) chk("wrap.to0", 32'(ho1), 32'd0);
        end

        // Randomized traffic; req changes sparingly so tenure limits get hit.
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 3) == 0) req = 4'($urandom);
            data = 4'($urandom);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
